// File: rtl/serial_adder.sv
`timescale 1ns/1ps
`default_nettype none
// serial_adder: multi-cycle LSB-first adder/subtractor, SLICE bits per clock.
// Rev 1.0
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic [SLICE:0]   w_slice;
  logic             w_cmsb;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_ins;
  logic [WIDTH-1:0] w_acc_next;

  assign w_slice    = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_b[SLICE-1:0]} + {{SLICE{1'b0}}, r_c};
  // Carry into the slice MSB recovered from its sum bit and operand bits.
  assign w_cmsb     = r_a[SLICE-1] ^ r_b[SLICE-1] ^ w_slice[SLICE-1];
  assign w_ins      = WIDTH'(w_slice[SLICE-1:0]) << (WIDTH - SLICE);
  assign w_acc_next = (r_acc >> SLICE) | w_ins;
  assign w_accept   = start && (r_state != S_RUN);
  assign w_last     = (r_state == S_RUN) && (r_cnt == C_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= sub ? ~b : b;
        r_c   <= cin ^ sub;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_a   <= r_a >> SLICE;
        r_b   <= r_b >> SLICE;
        r_c   <= w_slice[SLICE];
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + CW'(1);
        // Visible result only changes on the final slice.
        if (w_last) begin
          r_sum  <= w_acc_next;
          r_cout <= w_slice[SLICE];
          r_ovf  <= w_cmsb ^ w_slice[SLICE];
        end
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
`default_nettype none
// tb_serial_adder: randomized and directed checks of serial_adder in three configurations.
// Rev 1.0
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  st  = '0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a   = '0;
  logic [15:0] b   = '0;
  logic [2:0]  busy_v, done_v, cout_v, ovf_v;
  logic [7:0]  sum_m, sum_s;
  logic [15:0] sum_w;

  int          n_chk = 0;
  int          n_err = 0;
  int          both_cnt = 0;
  logic [15:0] prev_sum [3] = '{16'h0, 16'h0, 16'h0};

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .SLICE(1)) u_dut (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_m), .cout(cout_v[0]), .overflow(ovf_v[0]));

  serial_adder #(.WIDTH(16), .SLICE(4)) u_dut_w16 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_w), .cout(cout_v[1]), .overflow(ovf_v[1]));

  serial_adder #(.WIDTH(8), .SLICE(8)) u_dut_s8 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_s), .cout(cout_v[2]), .overflow(ovf_v[2]));

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      if (busy_v[k] && done_v[k]) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int k);
    return (k == 1) ? 16 : 8;
  endfunction

  function automatic int nslices(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 4 : 1);
  endfunction

  function automatic logic [15:0] get_sum(input int k);
    return (k == 0) ? {8'h0, sum_m} : ((k == 1) ? sum_w : {8'h0, sum_s});
  endfunction

  // Reference: {overflow, cout, sum} from integer arithmetic on unsigned and signed views.
  function automatic logic [17:0] model(input int w, input logic s, input logic [15:0] xa,
                                        input logic [15:0] xb, input logic c);
    longint m, ua, ub, sa, sb, cc, r, sr;
    logic co, ov;
    logic [15:0] res;
    m  = longint'(1) << w;
    ua = longint'(xa) & (m - 1);
    ub = longint'(xb) & (m - 1);
    cc = c ? 1 : 0;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!s) begin
      r  = ua + ub + cc;
      co = (r >= m);
      sr = sa + sb + cc;
    end else begin
      r  = ua - ub - cc;
      co = (r >= 0);
      sr = sa - sb - cc;
    end
    ov  = (sr >= m / 2) || (sr < -(m / 2));
    res = 16'(r & (m - 1));
    return {ov, co, res};
  endfunction

  task automatic start_op(input int k, input logic s, input logic [15:0] aa,
                          input logic [15:0] bb, input logic c);
    @(negedge clk);
    sub = s; a = aa; b = bb; cin = c; st[k] = 1'b1;
    @(posedge clk);
    #1;
    st[k] = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_done(input int k, output int lat, output int bn);
    lat = 0;
    bn  = busy_v[k] ? 1 : 0;
    while (!done_v[k] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy_v[k]) bn++;
    end
    if (!done_v[k]) check("done_timeout", {31'b0, done_v[k]}, 32'd1);
  endtask

  task automatic run_op(input int k, input logic s, input logic [15:0] aa,
                        input logic [15:0] bb, input logic c, input string tag);
    logic [17:0] e;
    logic [15:0] ma, mb;
    int lat, bn;
    ma = (width_of(k) == 16) ? aa : {8'h0, aa[7:0]};
    mb = (width_of(k) == 16) ? bb : {8'h0, bb[7:0]};
    e  = model(width_of(k), s, ma, mb, c);
    start_op(k, s, ma, mb, c);
    check({tag, ".held"}, get_sum(k), prev_sum[k]);
    wait_done(k, lat, bn);
    check({tag, ".lat"},  lat, nslices(k));
    check({tag, ".busy"}, bn,  nslices(k));
    check({tag, ".sum"},  get_sum(k), e[15:0]);
    check({tag, ".cout"}, cout_v[k], e[16]);
    check({tag, ".ovf"},  ovf_v[k],  e[17]);
    prev_sum[k] = e[15:0];
  endtask

  initial begin
    int lat, bn, dn;
    logic [17:0] e;

    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", busy_v[0], 1'b0);
    check("rst.done", done_v[0], 1'b0);
    check("rst.sum",  sum_m, 8'h00);
    check("rst.cout", cout_v[0], 1'b0);
    check("rst.ovf",  ovf_v[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 1'b0, 16'h005A, 16'h0033, 1'b0, "add_5a_33");
    run_op(0, 1'b0, 16'h00FF, 16'h0000, 1'b1, "add_wrap");
    run_op(0, 1'b1, 16'h0010, 16'h0020, 1'b0, "sub_borrow");
    run_op(0, 1'b1, 16'h0080, 16'h0001, 1'b0, "sub_ovf");
    run_op(1, 1'b0, 16'h1234, 16'hEDCC, 1'b0, "w16_s4");
    run_op(2, 1'b0, 16'h0070, 16'h0011, 1'b1, "w8_s8");

    // Start during RUN with different operands must be ignored.
    start_op(0, 1'b0, 16'h0011, 16'h0022, 1'b0);
    @(posedge clk);
    @(negedge clk);
    a = 16'h00F0; b = 16'h00F0; sub = 1'b1; st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    wait_done(0, lat, bn);
    check("midrun.lat", lat + 2, 8);
    check("midrun.sum", sum_m, 8'h33);
    @(posedge clk);
    #1;
    check("midrun.noqueue", busy_v[0], 1'b0);
    prev_sum[0] = 16'h0033;

    // Back-to-back: second start issued in the DONE cycle.
    run_op(0, 1'b0, 16'h0001, 16'h0002, 1'b0, "b2b_first");
    e = model(8, 1'b1, 16'h0040, 16'h0003, 1'b1);
    start_op(0, 1'b1, 16'h0040, 16'h0003, 1'b1);
    wait_done(0, lat, bn);
    check("b2b.gap", lat + 1, 9);
    check("b2b.sum", sum_m, e[7:0]);
    prev_sum[0] = {8'h0, e[7:0]};

    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
      run_op(k, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in RUN cycle 3.
    start_op(0, 1'b0, 16'h005A, 16'h0033, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst.busy", busy_v[0], 1'b0);
    check("arst.done", done_v[0], 1'b0);
    check("arst.sum",  sum_m, 8'h00);
    check("arst.cout", cout_v[0], 1'b0);
    check("arst.ovf",  ovf_v[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_v[0]) dn++;
    end
    check("arst.nodone", dn, 0);
    prev_sum = '{16'h0, 16'h0, 16'h0};

    // Reset released with start already high.
    @(negedge clk);
    rst = 1'b1;
    st[0] = 1'b1; a = 16'h000F; b = 16'h0001; sub = 1'b0; cin = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    check("rstrel.accept", busy_v[0], 1'b1);
    wait_done(0, lat, bn);
    check("rstrel.lat", lat, 8);
    check("rstrel.sum", sum_m, 8'h10);
    prev_sum[0] = 16'h0010;

    run_op(0, 1'b1, 16'h0003, 16'h0005, 1'b1, "post_rst");

    check("busy_done_excl", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
